// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped branch target buffer for the fetch stage.
//               Fetch presents lookup_pc and gets a combinational hit,
//               taken prediction and predicted next PC. Execute writes back
//               resolved branches; each entry holds a tag, a 32-bit target
//               and a saturating direction counter. Also provides a bulk
//               flush and a saturating direction-mispredict counter.
// Ports       : CLK, RST             - clock, synchronous active-high reset
//               lookup_pc            - fetch PC (pc[1:0] ignored)
//               hit / predict_taken / predict_target - lookup results
//               enable               - pipeline advance, gates all updates
//               update_en/_pc/_taken/_target/_pred_taken - resolved branch
//               flush_all            - invalidate every entry
//               mispredict_cnt       - saturating mispredict count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      lookup_pc,
    output logic             hit,
    output logic             predict_taken,
    output logic [31:0]      predict_target,
    input  logic             enable,
    input  logic             update_en,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_pred_taken,
    input  logic             flush_all,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int                  c_idx_w    = $clog2(ENTRIES);
    localparam int                  c_tag_w    = 32 - c_idx_w - 2;
    localparam logic [CTR_BITS-1:0] c_ctr_max  = '1;
    localparam logic [CTR_BITS-1:0] c_ctr_one  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] c_ctr_weak = c_ctr_one << (CTR_BITS - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]    c_cnt_one  = CNT_W'(1);

    // Table storage. Only valid bits and counters are reset; tags and
    // targets are meaningless while the entry is invalid.
    logic [ENTRIES-1:0]  r_valid;
    logic [c_tag_w-1:0]  r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [CNT_W-1:0]    r_mis_cnt;

    logic [c_idx_w-1:0]  w_lk_idx;
    logic [c_tag_w-1:0]  w_lk_tag;
    logic [c_idx_w-1:0]  w_up_idx;
    logic [c_tag_w-1:0]  w_up_tag;
    logic                w_up_hit;
    logic                w_up_qual;
    logic                w_mispredict;
    logic                w_unused_bits;

    // ------------------------------------------------------------------
    // Lookup (combinational, reads pre-update state: no bypass)
    // ------------------------------------------------------------------
    assign w_lk_idx       = lookup_pc[c_idx_w+1:2];
    assign w_lk_tag       = lookup_pc[31:c_idx_w+2];
    assign hit            = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predict_taken  = hit && r_ctr[w_lk_idx][CTR_BITS-1];
    assign predict_target = predict_taken ? r_target[w_lk_idx] : (lookup_pc + 32'd4);

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    assign w_up_idx      = update_pc[c_idx_w+1:2];
    assign w_up_tag      = update_pc[31:c_idx_w+2];
    assign w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_qual     = enable && update_en;
    assign w_mispredict  = update_pred_taken != update_taken;
    // Byte-offset bits of the update PC carry no information.
    assign w_unused_bits = &{1'b0, update_pc[1:0]};

    // ------------------------------------------------------------------
    // Table state. Flush wins over a same-cycle update.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= '0;
            end
        end else if (enable) begin
            if (flush_all) begin
                r_valid <= '0;
                for (int i = 0; i < ENTRIES; i++) begin
                    r_ctr[i] <= '0;
                end
            end else if (update_en) begin
                if (w_up_hit) begin
                    if (update_taken) begin
                        if (r_ctr[w_up_idx] != c_ctr_max) begin
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + c_ctr_one;
                        end
                        r_target[w_up_idx] <= update_target;
                    end else if (r_ctr[w_up_idx] != '0) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] - c_ctr_one;
                    end
                end else if (update_taken) begin
                    // Allocate / replace; a not-taken miss never evicts.
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= update_target;
                    r_ctr[w_up_idx]    <= c_ctr_weak;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mispredict counter: counts even when a flush discards the update.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mis_cnt <= '0;
        end else if (w_up_qual && w_mispredict && (r_mis_cnt != c_cnt_max)) begin
            r_mis_cnt <= r_mis_cnt + c_cnt_one;
        end
    end

    assign mispredict_cnt = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Self-checking bench for branch_target_buffer (16 entries,
//               2-bit counters, 16-bit mispredict counter). A behavioural
//               table model is compared against the DUT every cycle, and
//               directed literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] lookup_pc = 32'h0;
    logic        hit;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        enable = 1'b0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = 32'h0;
    logic        update_pred_taken = 1'b0;
    logic        flush_all = 1'b0;
    logic [15:0] mispredict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_target_buffer #(
        .ENTRIES  (16),
        .CTR_BITS (2),
        .CNT_W    (16)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .lookup_pc         (lookup_pc),
        .hit               (hit),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .enable            (enable),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_pred_taken (update_pred_taken),
        .flush_all         (flush_all),
        .mispredict_cnt    (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model: plain integer table, index = word address mod 16
    // ------------------------------------------------------------------
    bit          m_valid  [16];
    longint      m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int          m_cnt = 0;
    bit          m_known = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % 16);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc) / 64;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state update at each rising edge (inputs are stable here)
    initial forever begin
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 0;
            end
            m_cnt   = 0;
            m_known = 1;
        end else if (enable) begin
            if (update_en && (update_pred_taken != update_taken) && m_cnt < 65535)
                m_cnt = m_cnt + 1;
            if (flush_all) begin
                for (int i = 0; i < 16; i++) begin
                    m_valid[i] = 0;
                    m_ctr[i]   = 0;
                end
            end else if (update_en) begin
                int     k;
                longint t;
                k = idx_of(update_pc);
                t = tag_of(update_pc);
                if (m_valid[k] && m_tag[k] == t) begin
                    if (update_taken) begin
                        m_ctr[k]    = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
                        m_target[k] = update_target;
                    end else begin
                        m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
                    end
                end else if (update_taken) begin
                    m_valid[k]  = 1;
                    m_tag[k]    = t;
                    m_target[k] = update_target;
                    m_ctr[k]    = 2;
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge
    initial forever begin
        @(negedge CLK);
        if (m_known) begin
            int          k;
            bit          e_hit;
            bit          e_pt;
            logic [31:0] e_tgt;
            k     = idx_of(lookup_pc);
            e_hit = m_valid[k] && (m_tag[k] == tag_of(lookup_pc));
            e_pt  = e_hit && (m_ctr[k] >= 2);
            e_tgt = e_pt ? m_target[k] : 32'(longint'(lookup_pc) + 4);
            check("model_hit",    {31'd0, hit},           {31'd0, e_hit});
            check("model_ptaken", {31'd0, predict_taken}, {31'd0, e_pt});
            check("model_target", predict_target,         e_tgt);
            check("model_cnt",    {16'd0, mispredict_cnt}, 32'(m_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic en, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic pt, input logic fl);
        enable            = en;
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_pred_taken = pt;
        flush_all         = fl;
        tick();
        enable    = 1'b1;
        update_en = 1'b0;
        flush_all = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FFFC;
        if (r == 1) return $urandom;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        RST = 1'b1;
        tick();
        tick();
        RST       = 1'b0;
        enable    = 1'b1;
        lookup_pc = 32'h40;
        #1;
        check("reset_hit",    {31'd0, hit},           32'd0);
        check("reset_ptaken", {31'd0, predict_taken}, 32'd0);
        check("reset_target", predict_target,         32'h44);
        check("reset_cnt",    {16'd0, mispredict_cnt}, 32'd0);

        // Allocate 0x40 -> 0x100, mispredicted
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        check("alloc_hit",    {31'd0, hit},           32'd1);
        check("alloc_ptaken", {31'd0, predict_taken}, 32'd1);
        check("alloc_target", predict_target,         32'h100);
        check("alloc_cnt",    {16'd0, mispredict_cnt}, 32'd1);

        // Two not-taken: 10 -> 01 -> 00
        upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        check("nt1_ptaken", {31'd0, predict_taken}, 32'd0);
        check("nt1_target", predict_target,         32'h44);
        check("nt1_cnt",    {16'd0, mispredict_cnt}, 32'd2);
        upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        check("nt2_hit", {31'd0, hit},           32'd1);
        check("nt2_cnt", {16'd0, mispredict_cnt}, 32'd3);
        // Further not-taken holds at 00; one taken then only reaches 01
        upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        upd(1'b1, 32'h40, 1'b1, 32'h180, 1'b0, 1'b0);
        check("sat0_ptaken", {31'd0, predict_taken}, 32'd0);
        check("sat0_target", predict_target,         32'h44);
        check("sat0_cnt",    {16'd0, mispredict_cnt}, 32'd5);

        // Alias 0x80 on index 0 replaces 0x40
        upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
        check("alias_old_hit", {31'd0, hit}, 32'd0);
        lookup_pc = 32'h80;
        #1;
        check("alias_new_hit",    {31'd0, hit},   32'd1);
        check("alias_new_target", predict_target, 32'h200);
        // Not-taken miss on 0x40 must not evict 0x80
        upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        check("nt_miss_keep", {31'd0, hit},           32'd1);
        check("nt_miss_cnt",  {16'd0, mispredict_cnt}, 32'd6);

        // enable=0 blocks update, flush and counter
        upd(1'b0, 32'h40, 1'b1, 32'h300, 1'b1, 1'b1);
        check("gated_hit", {31'd0, hit},           32'd1);
        check("gated_cnt", {16'd0, mispredict_cnt}, 32'd6);

        // Flush with a mispredicting update: flush wins, counter counts
        upd(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
        check("flush_hit", {31'd0, hit},           32'd0);
        check("flush_cnt", {16'd0, mispredict_cnt}, 32'd7);

        // Wrap of the fall-through address
        lookup_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_target", predict_target, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            lookup_pc         = rand_pc();
            RST               = ($urandom_range(0, 99) < 2);
            enable            = ($urandom_range(0, 9) < 8);
            update_en         = ($urandom_range(0, 9) < 6);
            update_pc         = rand_pc();
            update_taken      = 1'($urandom);
            update_target     = $urandom;
            update_pred_taken = 1'($urandom);
            flush_all         = ($urandom_range(0, 99) < 3);
            tick();
        end
        RST       = 1'b0;
        flush_all = 1'b0;

        // Drive the mispredict counter into saturation
        begin
            int need;
            need = 65535 - m_cnt + 3;
            enable            = 1'b1;
            update_en         = 1'b1;
            update_taken      = 1'b0;
            update_pred_taken = 1'b1;
            for (int n = 0; n < need; n++) begin
                update_pc = rand_pc();
                lookup_pc = rand_pc();
                tick();
            end
        end
        check("cnt_saturated", {16'd0, mispredict_cnt}, 32'h0000_FFFF);
        tick();
        check("cnt_hold", {16'd0, mispredict_cnt}, 32'h0000_FFFF);

        // Reset together with a taken update: nothing allocated
        RST               = 1'b1;
        update_pc         = 32'h40;
        update_taken      = 1'b1;
        update_target     = 32'h500;
        update_pred_taken = 1'b0;
        tick();
        RST       = 1'b0;
        update_en = 1'b0;
        lookup_pc = 32'h40;
        #1;
        check("rst_upd_hit",    {31'd0, hit},           32'd0);
        check("rst_upd_target", predict_target,         32'h44);
        check("rst_upd_cnt",    {16'd0, mispredict_cnt}, 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters, used by the fetch stage of the pipelined MIPS datapath. Fetch looks up the current PC combinationally and gets a predicted next PC. The execute stage writes back each resolved branch outcome. It generalises the fixed single-branch predictor to configurable depth and counter width, adds tag checking, target storage and a bulk flush, and keeps a saturating mispredict counter for performance tracking.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, at least 2; IDX = log2(ENTRIES)
- CTR_BITS, 2, width of each direction counter; at least 1
- CNT_W, 16, width of the mispredict counter

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- lookup_pc  in  32  fetch-stage PC
- hit  out  1  valid entry whose tag matches lookup_pc
- predict_taken  out  1  hit and counter MSB = 1
- predict_target  out  32  predicted next PC
- enable  in  1  pipeline advance (ihit || dhit); gates every state update
- update_en  in  1  resolved BEQ/BNE present in EX this cycle
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual branch outcome
- update_target  in  32  actual branch target
- update_pred_taken  in  1  prediction that was made for this branch, carried down the pipe
- flush_all  in  1  invalidate every entry
- mispredict_cnt  out  CNT_W  saturating count of direction mispredicts

## Operation
- PC fields:
  - index = pc[IDX+1:2]
  - tag = pc[31:IDX+2]
  - pc[1:0] is ignored.
- Each entry stores valid, tag, a 32-bit target and a CTR_BITS counter.
- Lookup is purely combinational from lookup_pc and the current table state:
  - hit = valid[idx] && tag[idx] == lookup tag.
  - predict_taken = hit && ctr[idx][CTR_BITS-1].
  - predict_target = stored target when predict_taken, else lookup_pc + 4. The add is 32-bit and wraps: 0xFFFFFFFC + 4 = 0x00000000.
- An update is performed when RST=0, enable=1 and update_en=1.
- Update on a hit (entry at update_pc index is valid with a matching tag):
  - counter increments, saturating at all-ones, if taken; decrements, saturating at 0, if not taken.
  - target is overwritten with update_target only if taken.
- Update on a miss, taken: allocate or replace the entry.
  - valid = 1, tag = update tag, target = update_target.
  - counter = weakly taken = 1 << (CTR_BITS-1).
- Update on a miss, not taken: table is unchanged.
- Mispredict counting:
  - a mispredict is update_pred_taken != update_taken during a qualifying update.
  - mispredict_cnt increments by 1 and holds at 2^CNT_W - 1.
- flush_all, when enable=1:
  - all valid bits and counters are cleared at the edge.
  - flush has priority over a simultaneous table update; that update is discarded.
  - the mispredict counter still counts a simultaneous mispredict.
- enable=0: no state changes at all. This includes flush_all, update and the counter.

## Timing
- Reset, on any edge with RST=1 and regardless of enable or update_en:
  - all valid bits = 0, all counters = 0, mispredict_cnt = 0.
  - stored targets and tags are don't-care.
- Outputs after reset: hit = 0, predict_taken = 0, predict_target = lookup_pc + 4, mispredict_cnt = 0.
- Reset asserted mid-stream discards any same-cycle update or flush.
- Lookup latency is 0 cycles (combinational).
- Update latency: visible to lookup on the cycle after the qualifying edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update state; there is no bypass.
- Index aliasing: an update to a different tag at the same index replaces the entry only when taken. A not-taken miss never evicts.
- mispredict_cnt is registered and changes only on the qualifying edge.

## Test plan
ENTRIES=16, CTR_BITS=2, CNT_W=16 throughout; 0x40 and 0x80 share index 0.
- Reset, then lookup_pc=0x40 -> hit=0, predict_taken=0, predict_target=0x44, mispredict_cnt=0.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0, enable=1 -> next cycle, lookup 0x40 gives hit=1, predict_taken=1, predict_target=0x100, mispredict_cnt=1.
- Then two not-taken updates on 0x40 with pred_taken=1 -> counter goes 10→01→00; predict_taken=0 after the first; target=0x44; mispredict_cnt=3. A further not-taken update holds the counter at 00.
- Taken update pc=0x80, target=0x200 -> lookup 0x40 hit=0; lookup 0x80 hit=1, target 0x200. A not-taken update pc=0x40 then leaves 0x80 resident.
- Update with enable=0 -> table and mispredict_cnt unchanged. flush_all plus a mispredicting update with enable=1 -> all lookups hit=0, mispredict_cnt +1.
- Counter at 0xFFFF plus a mispredict -> stays 0xFFFF. RST asserted together with update_en -> all cleared, no allocation.
